// File: rtl/segment_sequencer.sv
// Double-buffered segment sequencer: plays a latched segment's index
// ramp at a divided tick rate and swaps segments at loop boundaries.
module segment_sequencer #(
  parameter int NUM_SEGMENTS = 2,
  parameter int CYCLE_WIDTH = 15,
  parameter int DIV_WIDTH = 16,
  parameter int REP_WIDTH = 16,
  localparam int SEL_W = $clog2(NUM_SEGMENTS)
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic TICK,
  input  logic UPDATE_SETTINGS,
  input  logic [SEL_W-1:0] REQ_SEGMENT,
  input  logic [NUM_SEGMENTS*CYCLE_WIDTH-1:0] CYCLE,
  input  logic [NUM_SEGMENTS*DIV_WIDTH-1:0] FREQ_DIV,
  input  logic [NUM_SEGMENTS*REP_WIDTH-1:0] REP,
  output logic [CYCLE_WIDTH-1:0] IDX,
  output logic [SEL_W-1:0] SEGMENT,
  output logic STOPPED,
  output logic SWAP_DONE
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PENDING,
    HALT
  } state_t;

  state_t state;

  logic [DIV_WIDTH-1:0] div_cnt;
  logic [REP_WIDTH-1:0] loop_cnt;

  logic [CYCLE_WIDTH-1:0] act_cycle;
  logic [DIV_WIDTH-1:0] act_div;
  logic [REP_WIDTH-1:0] act_rep;

  logic [SEL_W-1:0] pend_seg;
  logic [CYCLE_WIDTH-1:0] pend_cycle;
  logic [DIV_WIDTH-1:0] pend_div;
  logic [REP_WIDTH-1:0] pend_rep;

  logic [CYCLE_WIDTH-1:0] sel_cycle;
  logic [DIV_WIDTH-1:0] sel_div;
  logic [REP_WIDTH-1:0] sel_rep;

  logic req_ok;
  logic [DIV_WIDTH-1:0] div_last;
  logic playing;
  logic step;
  logic at_end;
  logic infinite;
  logic last_loop;
  logic [REP_WIDTH-1:0] loop_inc;

  // Pick the requested segment's config slices off the input buses.
  always_comb begin
    sel_cycle = '0;
    sel_div = '0;
    sel_rep = '0;
    for (int k = 0; k < NUM_SEGMENTS; k++) begin
      if (REQ_SEGMENT == SEL_W'(k)) begin
        sel_cycle = CYCLE[k*CYCLE_WIDTH +: CYCLE_WIDTH];
        sel_div = FREQ_DIV[k*DIV_WIDTH +: DIV_WIDTH];
        sel_rep = REP[k*REP_WIDTH +: REP_WIDTH];
      end
    end
  end

  // Advance conditions; a divider of zero steps on every tick.
  always_comb begin
    req_ok = UPDATE_SETTINGS &&
             (32'(REQ_SEGMENT) < NUM_SEGMENTS);
    div_last = (act_div == '0) ? '0 :
               act_div - DIV_WIDTH'(1);
    playing = (state == RUN) || (state == PENDING);
    step = TICK && playing && (div_cnt == div_last);
    at_end = (IDX == act_cycle);
    infinite = &act_rep;
    last_loop = !infinite && (loop_cnt == act_rep);
    loop_inc = (&loop_cnt) ? loop_cnt :
               loop_cnt + REP_WIDTH'(1);
  end

  // Sequencer state, playback counters and registered outputs.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= IDLE;
      IDX <= '0;
      SEGMENT <= '0;
      STOPPED <= 1'b0;
      SWAP_DONE <= 1'b0;
      div_cnt <= '0;
      loop_cnt <= '0;
      act_cycle <= '0;
      act_div <= '0;
      act_rep <= '0;
      pend_seg <= '0;
      pend_cycle <= '0;
      pend_div <= '0;
      pend_rep <= '0;
    end else begin
      SWAP_DONE <= 1'b0;
      if (req_ok) begin
        pend_seg <= REQ_SEGMENT;
        pend_cycle <= sel_cycle;
        pend_div <= sel_div;
        pend_rep <= sel_rep;
      end
      if (TICK && playing) begin
        div_cnt <= step ? '0 : div_cnt + DIV_WIDTH'(1);
      end
      unique case (state)
        IDLE, HALT: begin
          if (req_ok) begin
            state <= RUN;
            SEGMENT <= REQ_SEGMENT;
            act_cycle <= sel_cycle;
            act_div <= sel_div;
            act_rep <= sel_rep;
            IDX <= '0;
            div_cnt <= '0;
            loop_cnt <= '0;
            SWAP_DONE <= 1'b1;
            STOPPED <= 1'b0;
          end
        end
        RUN: begin
          if (req_ok) state <= PENDING;
          if (step) begin
            if (!at_end) begin
              IDX <= IDX + CYCLE_WIDTH'(1);
            end else if (last_loop) begin
              // Hold the last index; a fresh request turns the
              // terminating wrap into a swap at the next advance.
              if (!req_ok) begin
                state <= HALT;
                STOPPED <= 1'b1;
              end
            end else begin
              IDX <= '0;
              loop_cnt <= loop_inc;
            end
          end
        end
        PENDING: begin
          if (step) begin
            if (!at_end) begin
              IDX <= IDX + CYCLE_WIDTH'(1);
            end else begin
              SEGMENT <= pend_seg;
              act_cycle <= pend_cycle;
              act_div <= pend_div;
              act_rep <= pend_rep;
              IDX <= '0;
              loop_cnt <= '0;
              SWAP_DONE <= 1'b1;
              if (!req_ok) state <= RUN;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
